apb_wait_slave: RTL and testbench

APB completer that sits directly downstream of the team's APB master and consumes its psel/penable/pwrite/paddr/pwdata phases. It holds a DEPTH x DATA_W register memory and inserts a programmable number of wait states before asserting pready. It flags out-of-range addresses and protocol violations on pslverr. One instance sits behind each master select line (psel1/psel2); the master's paddr bit 8 is decoded outside this block.

---
 rtl/apb_pkg.sv | 8 +
 rtl/apb_slave_ram.sv | 26 ++
 rtl/apb_wait_slave.sv | 104 ++++++++++
 tb/tb_apb_wait_slave.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// apb_pkg: state and error-code encodings shared by the APB master and its wait-state slaves.
package apb_pkg;
    localparam int APB_ADDR_W = 8;
    localparam int APB_DATA_W = 8;
    typedef enum logic {IDLE, ACCESS} state_t;
    // Any code other than ERR_NONE is reported as pslverr on the completing cycle.
    typedef enum logic [1:0] {ERR_NONE, ERR_RANGE, ERR_PROTO, ERR_WPROT} err_t;
endpackage

// File: rtl/apb_slave_ram.sv
// apb_slave_ram: DEPTH x DATA_W array with synchronous write and a registered, resettable read port.
module apb_slave_ram #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 64,
    localparam int IW    = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              we,
    input  logic [IW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic              rzero,
    input  logic [IW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge pclk)
        if (we) mem[waddr] <= wdata;

    // Out-of-range reads load zero instead of an aliased word.
    always_ff @(posedge pclk)
        if (!presetn) rdata <= '0;
        else if (re) rdata <= rzero ? '0 : mem[raddr];
endmodule

// File: rtl/apb_wait_slave.sv
// apb_wait_slave: APB completer with a register memory and WAIT_CYCLES wait states before pready.
// Define APB_WAIT_SLAVE_WR_PROTECT_EN to reject writes to indices PROT_BASE..DEPTH-1.
module apb_wait_slave
    import apb_pkg::*;
#(
    parameter int ADDR_W      = APB_ADDR_W,
    parameter int DATA_W      = APB_DATA_W,
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2,
    parameter int PROT_BASE   = 56
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [DATA_W-1:0] pwdata,
    output logic [DATA_W-1:0] prdata,
    output logic              pready,
    output logic              pslverr
);
    localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = WAIT_CYCLES > 0 ? $clog2(WAIT_CYCLES + 1) : 1;
`ifdef APB_WAIT_SLAVE_WR_PROTECT_EN
    localparam bit WP_EN = 1'b1;
`else
    localparam bit WP_EN = 1'b0;
`endif

    state_t            state, state_nx;
    logic [CW-1:0]     cnt, cnt_nx;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_data;
    logic              lat_dir;
    logic              setup, in_range, lat_ok, wprot, we;
    err_t              err;

    assign setup    = state == IDLE && psel && !penable;
    assign in_range = 32'(paddr) < DEPTH;
    assign lat_ok   = 32'(lat_addr) < DEPTH;
    assign wprot    = WP_EN && lat_dir && 32'(lat_addr) >= PROT_BASE;

    always_ff @(posedge pclk)
        if (!presetn) begin
            state    <= IDLE;
            cnt      <= '0;
            lat_addr <= '0;
            lat_data <= '0;
            lat_dir  <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (setup) begin
                lat_addr <= paddr;
                lat_data <= pwdata;
                lat_dir  <= pwrite;
            end
        end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        pready   = 1'b0;
        err      = ERR_NONE;
        if (state == IDLE) begin
            if (psel && penable) begin
                pready = 1'b1;
                err    = ERR_PROTO;
            end else if (psel) begin
                state_nx = ACCESS;
                cnt_nx   = CW'(WAIT_CYCLES);
            end
        end else if (!psel) begin
            state_nx = IDLE;
        end else if (penable) begin
            if (cnt != '0) cnt_nx = cnt - 1'b1;
            else begin
                pready   = 1'b1;
                state_nx = IDLE;
                err      = !lat_ok ? ERR_RANGE : wprot ? ERR_WPROT : ERR_NONE;
            end
        end
        if (!presetn) begin
            pready = 1'b0;
            err    = ERR_NONE;
        end
    end

    assign pslverr = pready && err != ERR_NONE;
    assign we      = pready && state == ACCESS && lat_dir && err == ERR_NONE;

    apb_slave_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ram (
        .pclk    (pclk),
        .presetn (presetn),
        .we      (we),
        .waddr   (lat_addr[IW-1:0]),
        .wdata   (lat_data),
        .re      (setup && !pwrite),
        .rzero   (!in_range),
        .raddr   (paddr[IW-1:0]),
        .rdata   (prdata)
    );
endmodule

// File: tb/tb_apb_wait_slave.sv
// tb_apb_wait_slave: table-driven transfers on a 2-wait slave plus hand-written corner sequences.
module tb_apb_wait_slave;
    logic pclk = 1'b0, presetn = 1'b0;
    logic psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [7:0] paddr = '0, pwdata = '0, prdata;
    logic pready, pslverr;
    logic psel_z = 1'b0, penable_z = 1'b0, pwrite_z = 1'b0;
    logic [7:0] paddr_z = '0, pwdata_z = '0, prdata_z;
    logic pready_z, pslverr_z;
    int checks = 0, errors = 0;
`ifdef APB_WAIT_SLAVE_WR_PROTECT_EN
    localparam bit WP = 1'b1;
`else
    localparam bit WP = 1'b0;
`endif

    typedef struct {
        logic       w;
        logic [7:0] a;
        logic [7:0] d;
        logic       err;
        logic [7:0] rd;
    } vec_t;
    vec_t vt[$];

    always #5 pclk = ~pclk;

    apb_wait_slave dut (
        .pclk(pclk), .presetn(presetn), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    apb_wait_slave #(.WAIT_CYCLES(0)) dut_z (
        .pclk(pclk), .presetn(presetn), .psel(psel_z), .penable(penable_z), .pwrite(pwrite_z),
        .paddr(paddr_z), .pwdata(pwdata_z), .prdata(prdata_z), .pready(pready_z), .pslverr(pslverr_z)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Full transfer on the 2-wait slave; returns in the pready cycle so a following call is back-to-back.
    task automatic xfer(input vec_t v);
        int n;
        @(posedge pclk) #1;
        psel = 1'b1; penable = 1'b0; pwrite = v.w; paddr = v.a; pwdata = v.d;
        #3 chk("setup_pready", pready, 0);
        @(posedge pclk) #1;
        penable = 1'b1; pwrite = ~v.w; paddr = ~v.a; pwdata = ~v.d;
        for (n = 0; n <= 10; n++) begin
            #3;
            if (pready) break;
            @(posedge pclk) #1;
        end
        chk($sformatf("wait_cycles a=%0d", v.a), n, 2);
        chk($sformatf("pslverr a=%0d", v.a), pslverr, v.err);
        if (!v.w) chk($sformatf("prdata a=%0d", v.a), prdata, v.rd);
    endtask

    task automatic idle();
        @(posedge pclk) #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    initial begin
        vt.push_back('{1'b1, 8'd5,  8'hA5, 1'b0, 8'h00});
        vt.push_back('{1'b0, 8'd5,  8'h00, 1'b0, 8'hA5});
        vt.push_back('{1'b1, 8'd0,  8'h11, 1'b0, 8'h00});
        vt.push_back('{1'b0, 8'd0,  8'h00, 1'b0, 8'h11});
        vt.push_back('{1'b1, 8'd40, 8'h5A, 1'b0, 8'h00});
        vt.push_back('{1'b0, 8'd40, 8'h00, 1'b0, 8'h5A});
        vt.push_back('{1'b0, 8'd70, 8'h00, 1'b1, 8'h00});
        vt.push_back('{1'b1, 8'd70, 8'h77, 1'b1, 8'h00});
        vt.push_back('{1'b1, 8'd9,  8'h42, 1'b0, 8'h00});
        vt.push_back('{1'b0, 8'd9,  8'h00, 1'b0, 8'h42});
        vt.push_back('{1'b1, 8'd60, 8'hFF, WP,   8'h00});
        if (!WP) vt.push_back('{1'b0, 8'd60, 8'h00, 1'b0, 8'hFF});

        psel = 1'b1; penable = 1'b1;
        repeat (2) @(posedge pclk);
        #3;
        chk("rst_pready", pready, 0);
        chk("rst_pslverr", pslverr, 0);
        chk("rst_prdata", prdata, 0);
        @(posedge pclk) #1;
        psel = 1'b0; penable = 1'b0; presetn = 1'b1;

        foreach (vt[i]) xfer(vt[i]);
        idle();

        // Enable without setup is a protocol error that leaves the slave in IDLE.
        @(posedge pclk) #1;
        psel = 1'b1; penable = 1'b1;
        #3 chk("proto_pready", pready, 1);
        chk("proto_pslverr", pslverr, 1);
        @(posedge pclk) #1;
        psel = 1'b0; penable = 1'b0;
        #3 chk("proto_after_pready", pready, 0);
        xfer('{1'b0, 8'd5, 8'h00, 1'b0, 8'hA5});
        idle();

        // Abort a write to 9 in its first enable cycle.
        @(posedge pclk) #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'd9; pwdata = 8'h99;
        @(posedge pclk) #1;
        penable = 1'b1;
        #3 chk("abort_pready", pready, 0);
        @(posedge pclk) #1;
        psel = 1'b0; penable = 1'b0;
        #3 chk("abort_idle_pready", pready, 0);
        xfer('{1'b0, 8'd9, 8'h00, 1'b0, 8'h42});
        idle();

        // Reset lands on the would-be completing cycle of a write.
        @(posedge pclk) #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'd9; pwdata = 8'hEE;
        @(posedge pclk) #1;
        penable = 1'b1;
        repeat (2) @(posedge pclk);
        #1 presetn = 1'b0;
        #3 chk("rst_mid_pready", pready, 0);
        @(posedge pclk) #1;
        presetn = 1'b1; psel = 1'b0; penable = 1'b0;
        #3 chk("rst_mid_prdata", prdata, 0);
        xfer('{1'b0, 8'd9, 8'h00, 1'b0, 8'h42});
        idle();

        // Zero-wait slave: write then read back-to-back, two cycles each.
        @(posedge pclk) #1;
        psel_z = 1'b1; penable_z = 1'b0; pwrite_z = 1'b1; paddr_z = 8'd0; pwdata_z = 8'h3C;
        #3 chk("z_wr_setup_pready", pready_z, 0);
        @(posedge pclk) #1;
        penable_z = 1'b1;
        #3 chk("z_wr_pready", pready_z, 1);
        chk("z_wr_pslverr", pslverr_z, 0);
        @(posedge pclk) #1;
        penable_z = 1'b0; pwrite_z = 1'b0; pwdata_z = 8'h00;
        #3 chk("z_rd_setup_pready", pready_z, 0);
        @(posedge pclk) #1;
        penable_z = 1'b1;
        #3 chk("z_rd_pready", pready_z, 1);
        chk("z_rd_prdata", prdata_z, 8'h3C);
        chk("z_rd_pslverr", pslverr_z, 0);
        @(posedge pclk) #1;
        psel_z = 1'b0; penable_z = 1'b0;
        #3 chk("z_idle_pready", pready_z, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
